// File: rtl/axilite_reg_slave.sv
// AXI4-lite slave register bank: NUM_REGS x 32-bit byte-strobed registers.
// Optional macro AXIL_REG_SLAVE_PROT_CHECK_EN rejects unprivileged writes.
`timescale 1ns/1ps
module axilite_reg_slave #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    input  logic [31:0]              s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [29:0] LP_NREGS = 30'(NUM_REGS);

    wstate_t r_wstate, w_wnext;
    rstate_t r_rstate, w_rnext;

    logic w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;

    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] w_cmt_addr, w_cmt_data;
    logic [3:0]  w_cmt_strb;
    logic        w_cmt_ok;

    logic [31:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata, w_rd_val;
    logic        w_rd_ok;
    logic        w_unused;

    assign w_aw_hs = s_axi_awvalid & w_awready;
    assign w_w_hs  = s_axi_wvalid & w_wready;
    assign w_b_hs  = s_axi_bready & w_bvalid;
    assign w_ar_hs = s_axi_arvalid & w_arready;
    assign w_r_hs  = s_axi_rready & w_rvalid;

    // Completing handshake is the one that moves the write FSM into W_RESP
    assign w_commit = (r_wstate != W_RESP) && (w_wnext == W_RESP);

    assign w_cmt_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axi_awaddr;
    assign w_cmt_data = (r_wstate == W_HAVE_W) ? r_wdata : s_axi_wdata;
    assign w_cmt_strb = (r_wstate == W_HAVE_W) ? r_wstrb : s_axi_wstrb;

`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
    logic r_awprot0;
    logic w_cmt_prot0;
    assign w_cmt_prot0 = (r_wstate == W_HAVE_AW) ? r_awprot0 : s_axi_awprot[0];
    assign w_cmt_ok = (w_cmt_addr[31:2] < LP_NREGS) && w_cmt_prot0;

    // Privilege bit travels with the latched write address
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)
            r_awprot0 <= 1'b0;
        else if (w_aw_hs)
            r_awprot0 <= s_axi_awprot[0];
    end
`else
    assign w_cmt_ok = (w_cmt_addr[31:2] < LP_NREGS);
`endif

    assign w_unused = ^{w_cmt_addr[1:0], s_axi_araddr[1:0],
                        s_axi_arprot, s_axi_awprot};

    // Write FSM state register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wnext;
    end

    // Write FSM next state
    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs)
                    w_wnext = W_RESP;
                else if (w_aw_hs)
                    w_wnext = W_HAVE_AW;
                else if (w_w_hs)
                    w_wnext = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs) w_wnext = W_RESP;
            W_HAVE_W:  if (w_aw_hs) w_wnext = W_RESP;
            W_RESP:    if (w_b_hs) w_wnext = W_IDLE;
            default:   w_wnext = W_IDLE;
        endcase
    end

    // Write FSM outputs, forced low while reset is asserted
    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (!s_axi_areset) begin
            unique case (r_wstate)
                W_IDLE:    begin w_awready = 1'b1; w_wready = 1'b1; end
                W_HAVE_AW: w_wready  = 1'b1;
                W_HAVE_W:  w_awready = 1'b1;
                W_RESP:    w_bvalid  = 1'b1;
                default:   w_bvalid  = 1'b0;
            endcase
        end
    end

    // Hold whichever half of the write arrives first
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    // Register bank update, write pulse and write response code
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
            r_wr_pulse <= '0;
            r_bresp    <= 2'b00;
        end else begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_cmt_ok && w_cmt_addr[31:2] == 30'(i)) begin
                    r_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (w_cmt_strb[b])
                            r_regs[i][8*b +: 8] <= w_cmt_data[8*b +: 8];
                end
            end
            if (w_commit) r_bresp <= w_cmt_ok ? 2'b00 : 2'b10;
        end
    end

    // Read FSM state register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rnext;
    end

    // Read FSM next state
    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (w_r_hs) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read FSM outputs, forced low while reset is asserted
    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (!s_axi_areset) begin
            w_arready = (r_rstate == R_IDLE);
            w_rvalid  = (r_rstate == R_DATA);
        end
    end

    // Read mux; out-of-range indices yield zero
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (s_axi_araddr[31:2] == 30'(i)) w_rd_val = r_regs[i];
    end

    assign w_rd_ok = (s_axi_araddr[31:2] < LP_NREGS);

    // Capture read data at the address handshake (pre-write value on collision)
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_ok ? w_rd_val : 32'h0;
            r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = r_regs[g];
    end

    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_bvalid  = w_bvalid;
    assign s_axi_bresp   = s_axi_areset ? 2'b00 : r_bresp;
    assign s_axi_arready = w_arready;
    assign s_axi_rvalid  = w_rvalid;
    assign s_axi_rdata   = s_axi_areset ? 32'h0 : r_rdata;
    assign s_axi_rresp   = s_axi_areset ? 2'b00 : r_rresp;
    assign reg_wr_pulse  = s_axi_areset ? '0 : r_wr_pulse;

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Randomized self-checking bench for axilite_reg_slave.
// Reference model: plain array of registers updated per transaction.
`timescale 1ns/1ps
module tb_axilite_reg_slave;

    localparam int NR = 16;

    logic clk = 1'b0;
    logic areset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;
    logic [32*NR-1:0] reg_out;
    logic [NR-1:0] reg_wr_pulse;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_regs [NR];

    always #5 clk = ~clk;

    axilite_reg_slave #(.NUM_REGS(NR), .RESET_VAL(32'h0)) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_wresp(input logic [31:0] a,
                                             input logic [2:0] p);
        logic ok;
        ok = (a >> 2) < NR;
`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
        ok = ok && p[0];
`else
        if (p[0]) ok = ok;
`endif
        return ok ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check(tag, reg_out[32*i +: 32], m_regs[i]);
    endtask

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                            input logic [2:0] p, input int aw_dly,
                            input int w_dly, input int b_hold);
        bit aw_done = 0, w_done = 0, f_aw, f_w;
        int cyc = 0;
        logic [1:0] er;
        logic [NR-1:0] ep;
        @(posedge clk); #1;
        awaddr = a; awprot = p; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            @(negedge clk);
            if (w_done && !aw_done) check("wready_low", wready, 0);
            if (aw_done && !w_done) check("awready_low", awready, 0);
            f_aw = awvalid && awready;
            f_w  = wvalid && wready;
            @(posedge clk); #1;
            if (f_aw) aw_done = 1;
            if (f_w) w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        check("wr_hs_done", {30'b0, aw_done, w_done}, 32'd3);
        er = exp_wresp(a, p);
        ep = '0;
        if (er == 2'b00) begin
            m_regs[a >> 2] = merge(m_regs[a >> 2], d, s);
            ep[a >> 2] = 1'b1;
        end
        @(negedge clk);
        check("bvalid_up", bvalid, 1);
        check("bresp", bresp, er);
        check("wr_pulse", reg_wr_pulse, ep);
        check_regs("reg_out");
        for (int h = 0; h < b_hold; h++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, er);
            check("aw_w_ready_hold", {awready, wready}, 0);
        end
        @(posedge clk); #1;
        bready = 1;
        @(negedge clk);
        check("pulse_gone", reg_wr_pulse, 0);
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        check("bvalid_down", bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly,
                           input int r_hold, output logic [31:0] got);
        bit done = 0, f;
        int cyc = 0;
        logic [31:0] ed = '0;
        logic [1:0] er = 2'b00;
        @(posedge clk); #1;
        araddr = a; arprot = 3'($urandom);
        while (!done && cyc < 50) begin
            arvalid = cyc >= ar_dly;
            @(negedge clk);
            f = arvalid && arready;
            if (f) begin
                ed = ((a >> 2) < NR) ? m_regs[a >> 2] : 32'h0;
                er = ((a >> 2) < NR) ? 2'b00 : 2'b10;
            end
            @(posedge clk); #1;
            if (f) done = 1;
            cyc++;
        end
        arvalid = 0;
        check("rd_hs_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        got = rdata;
        check("rvalid_up", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        for (int h = 0; h < r_hold; h++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, ed);
            check("arready_hold", arready, 0);
        end
        @(posedge clk); #1;
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        @(negedge clk);
        check("rvalid_down", rvalid, 0);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return {$urandom_range(0, 19), 2'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, got2;
        areset = 1;
        awaddr = 0; awprot = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;

        @(negedge clk);
        check("rst_valid_ready", {awready, wready, bvalid, arready, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        repeat (2) @(posedge clk);
        #1 areset = 0;
        @(negedge clk);
        check_regs("rst_regs");
        check("idle_ready", {awready, wready, arready}, 3'b111);

        do_write(32'h08, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0);
        check("plan_reg2", reg_out[95:64], 32'hDEADBEEF);
        do_read(32'h08, 0, 0, got);
        check("plan_rd2", got, 32'hDEADBEEF);

        do_write(32'h04, 32'h11223344, 4'b0101, 3'b001, 3, 0, 0);
        check("plan_reg1", reg_out[63:32], 32'h00220044);

        do_write(32'h40, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0, 0);
        do_read(32'h40, 0, 0, got);
        check("plan_oor_rd", got, 32'h0);

        do_read(32'h00, 0, 5, got);
        do_write(32'h0C, 32'h12345678, 4'hF, 3'b001, 0, 0, 5);

        fork
            do_write(32'h0C, 32'hAAAA5555, 4'hF, 3'b001, 0, 0, 0);
            do_read(32'h0C, 0, 0, got);
        join
        check("plan_collide_old", got, 32'h12345678);
        do_read(32'h0C, 0, 0, got);
        check("plan_collide_new", got, 32'hAAAA5555);

`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
        do_write(32'h00, 32'h55555555, 4'hF, 3'b000, 0, 0, 0);
        check("prot_reg0", reg_out[31:0], 32'h0);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, ra;
            int op;
            op = $urandom_range(0, 2);
            a  = rnd_addr();
            ra = rnd_addr();
            if (op == 0)
                do_write(a, $urandom, 4'($urandom), 3'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            else if (op == 1)
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), got);
            else
                fork
                    do_write(a, $urandom, 4'($urandom), 3'($urandom),
                             $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 2));
                    do_read(($urandom_range(0, 1) == 1) ? a : ra,
                            $urandom_range(0, 2), $urandom_range(0, 2), got2);
                join
        end

        for (int i = 0; i < NR; i++)
            do_write(32'(i*4), 32'hA5000000 | 32'(i), 4'hF, 3'b001, 0, 0, 0);

        @(posedge clk); #1;
        awaddr = 32'h10; awprot = 3'b001; awvalid = 1;
        araddr = 32'h14; arvalid = 1;
        @(negedge clk);
        check("mid_aw_ready", {awready, arready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 0; arvalid = 0;
        @(negedge clk);
        check("mid_rvalid", rvalid, 1);
        check("mid_have_aw", {awready, wready}, 2'b01);
        @(posedge clk); #1;
        areset = 1;
        @(negedge clk);
        check("mid_rst_vr", {awready, wready, bvalid, arready, rvalid}, 0);
        check("mid_rst_rdata", rdata, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        @(negedge clk);
        check_regs("mid_rst_regs");
        @(posedge clk); #1;
        areset = 0;
        bready = 1; rready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_bvalid", bvalid, 0);
            check("post_rst_rvalid", rvalid, 0);
        end
        @(posedge clk); #1;
        bready = 0; rready = 0;
        do_read(32'h10, 0, 0, got);
        check("post_rst_rd", got, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axilite_reg_slave.md
Name: axilite_reg_slave

Overview:
- AXI4-lite slave register bank. Sits directly downstream of one master port of axilite_interconnect and consumes its m_axi_* channels.
- Receives offset addresses, since the interconnect has already subtracted the base.
- Holds NUM_REGS 32-bit read/write registers with byte strobes, and exposes their contents plus per-register write pulses to local logic.
- Independent read and write FSMs; full valid/ready handshakes on all five channels.

Parameters:
NUM_REGS, 16, number of 32-bit registers (1..256).
RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
s_axi_aclk  in  1  clock; all logic on rising edge
s_axi_areset  in  1  synchronous active-high reset
s_axi_awaddr  in  32  write byte offset
s_axi_awprot  in  3  write protection
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read byte offset
s_axi_arprot  in  3  read protection (ignored)
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  32*NUM_REGS  register contents; reg i at [32*i+:32]
reg_wr_pulse  out  NUM_REGS  1-cycle strobe when reg i is written

Behaviour:
- Clock and reset: single clock s_axi_aclk; s_axi_areset is synchronous, active-high.
- While reset is high:
  - all ready/valid outputs are 0; bresp, rresp, rdata and reg_wr_pulse are 0;
  - every register takes RESET_VAL;
  - both FSMs return to IDLE.
  - A reset mid-transaction discards it with no response.
- Address decode:
  - index = addr[31:2]; addr[1:0] is ignored.
  - index < NUM_REGS gives OKAY (2'b00).
  - Otherwise SLVERR (2'b10): no register update, rdata = 0.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - awready=1 in W_IDLE and W_HAVE_W; wready=1 in W_IDLE and W_HAVE_AW; both are 0 in W_RESP.
  - W_IDLE: if AW and W both handshake in the same cycle, commit and go to W_RESP. If AW only, latch addr/prot and go to W_HAVE_AW. If W only, latch data/strb and go to W_HAVE_W.
  - W_HAVE_AW: on W handshake, commit and go to W_RESP. W_HAVE_W: on AW handshake, commit and go to W_RESP.
  - Commit, on the edge of the completing handshake:
    - byte k of the register is updated iff wstrb[k]=1;
    - reg_wr_pulse[index]=1 for exactly the next cycle, even if wstrb=0;
    - the bresp code is latched.
  - W_RESP: bvalid=1, held stable until bready; on the handshake edge, bvalid drops and the FSM returns to W_IDLE.
  - Minimum timing: bvalid rises 1 cycle after the completing handshake; best case one write every 2 cycles.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture rdata/rresp from the current register value and go to R_DATA.
  - R_DATA: arready=0, rvalid=1; rdata/rresp stay stable until rready; on the handshake, return to R_IDLE.
  - rvalid rises 1 cycle after the AR handshake.
- Simultaneous events:
  - A read whose AR handshake occurs on the same edge as a commit to the same register returns the pre-write value.
  - Read and write paths never stall each other.
- reg_out reflects the register contents from the cycle after the commit edge.

Optional Feature:
- Macro: AXIL_REG_SLAVE_PROT_CHECK_EN.
- Defined: a write whose latched awprot[0]=0 (unprivileged) responds SLVERR, updates no register and produces no reg_wr_pulse, even when the index is in range. Reads are unaffected.
- Undefined: awprot is ignored; responses depend on the address only.

Test Plan:
- Reset, then AW=0x08 and W=0xDEADBEEF with strb=4'hF in the same cycle, bready=1: bvalid high 1 cycle later with bresp=00; reg_out[2]=0xDEADBEEF; reg_wr_pulse[2] high for 1 cycle. A read of 0x08 then returns 0xDEADBEEF with rresp=00.
- W (data 0x11223344, strb 4'b0101) issued 3 cycles before AW=0x04; reg 1 initially 0: wready drops after W; reg 1 becomes 0x00220044 on the AW edge.
- Write to 0x40 with NUM_REGS=16: bresp=10, no reg_wr_pulse, no register changes. Read of 0x40: rresp=10, rdata=0.
- Hold rready=0 for 5 cycles after a read of 0x00: rvalid stays 1, rdata stays stable and arready stays 0 until the handshake. Same check for bvalid with bready held low.
- AR=0x0C on the same edge as a commit of 0xAAAA5555 to reg 3 (old 0x12345678): rdata=0x12345678; a subsequent read returns 0xAAAA5555.
- Assert reset while in W_HAVE_AW and R_DATA: all valids go to 0, all registers reload RESET_VAL, no bvalid appears afterwards. With AXIL_REG_SLAVE_PROT_CHECK_EN defined, a write to 0x00 with awprot=3'b000 gives bresp=10 and reg 0 is unchanged.
